// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extends the selected immediate field to XLEN
// and carries it, with a pass-through tag, through one registered stage with a skid entry.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [2:0]       ImmSrc_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  ImmOp_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("imm_gen_pipe: TAG_W must be at least 1");
    end

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_RSVD  = 3'd7
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } beat_t;

    // Handshake: a beat moves whenever valid and ready are both high on a rising
    // edge; a producer holds valid and data stable until it sees that edge.

    logic [31:0] field32;
    logic        sign_fill;
    logic        ill_c;
    logic [XLEN-1:0] imm_c;
    beat_t       new_beat;
    logic        unused_opcode;

    assign unused_opcode = ^instr_i[6:0];

    // Every format is first assembled as a 32-bit value, then widened to XLEN.
    always_comb begin
        field32   = 32'd0;
        sign_fill = 1'b1;
        ill_c     = 1'b0;
        unique case (imm_src_e'(ImmSrc_i))
            IMM_I: field32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: field32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: field32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_J: field32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_U: field32 = {instr_i[31:12], 12'd0};
            IMM_Z: begin
                field32   = {27'd0, instr_i[19:15]};
                sign_fill = 1'b0;
            end
            IMM_SHAMT: begin
                sign_fill = 1'b0;
                if (XLEN == 64) begin
                    field32 = {26'd0, instr_i[25:20]};
                end else begin
                    field32 = {27'd0, instr_i[24:20]};
                    ill_c   = instr_i[25];
                end
            end
            IMM_RSVD: begin
                sign_fill = 1'b0;
                ill_c     = 1'b1;
            end
            default: begin
                sign_fill = 1'b0;
                ill_c     = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (sign_fill) begin
            imm_c = XLEN'($signed(field32));
        end else begin
            imm_c = XLEN'(field32);
        end
    end

    assign new_beat = '{imm: imm_c, tag: tag_i, ill: ill_c};

    logic  or_valid_q, or_valid_d;
    beat_t or_q, or_d;
    logic  sk_valid_q, sk_valid_d;
    beat_t sk_q, sk_d;
    logic  in_ready_q, in_ready_d;
    logic  accept;

    assign accept = in_valid_i && in_ready_q;

    // The skid entry only fills while the output register is held, so when it is
    // valid it is always the oldest beat waiting behind the output register.
    always_comb begin
        or_valid_d = or_valid_q;
        or_d       = or_q;
        sk_valid_d = sk_valid_q;
        sk_d       = sk_q;
        if (!or_valid_q || out_ready_i) begin
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_d       = sk_q;
                sk_valid_d = accept;
                if (accept) begin
                    sk_d = new_beat;
                end
            end else begin
                or_valid_d = accept;
                if (accept) begin
                    or_d = new_beat;
                end
            end
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_d       = new_beat;
        end
        in_ready_d = !sk_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            or_valid_q <= 1'b0;
            or_q       <= '0;
            sk_valid_q <= 1'b0;
            sk_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            or_valid_q <= or_valid_d;
            or_q       <= or_d;
            sk_valid_q <= sk_valid_d;
            sk_q       <= sk_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = or_valid_q;
    assign ImmOp_o     = or_q.imm;
    assign tag_o       = or_q.tag;
    assign illegal_o   = or_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are compared every cycle against a FIFO-of-beats model of the stage.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [2:0]  sel = 3'd0;
    logic [7:0]  tag = 8'd0;

    logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag32, tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .instr_i(instr), .ImmSrc_i(sel), .tag_i(tag), .out_valid_o(ov32),
        .out_ready_i(out_ready), .ImmOp_o(imm32), .tag_o(tag32), .illegal_o(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .instr_i(instr), .ImmSrc_i(sel), .tag_i(tag), .out_valid_o(ov64),
        .out_ready_i(out_ready), .ImmOp_o(imm64), .tag_o(tag64), .illegal_o(ill64)
    );

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [7:0]  tag;
        logic        ill32;
        logic        ill64;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    bit   cmp_on = 1'b0;
    bit   rnd_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic longint sext(input longint val, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (val >= half) ? val - 2 * half : val;
    endfunction

    // Immediate value as the instruction set defines it, computed as an integer.
    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t);
        exp_t   e;
        longint v;
        case (s)
            3'd0: v = sext(longint'(ins[31:20]), 12);
            3'd1: v = sext(longint'({ins[31:25], ins[11:7]}), 12);
            3'd2: v = sext(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            3'd3: v = sext(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            3'd4: v = sext(longint'(ins[31:12]), 20) * 4096;
            3'd5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        e.imm64 = v;
        e.imm32 = v[31:0];
        if (s == 3'd6) begin
            e.imm64 = 64'(ins[25:20]);
            e.imm32 = 32'(ins[24:20]);
        end
        e.tag   = t;
        e.ill32 = (s == 3'd7) || (s == 3'd6 && ins[25]);
        e.ill64 = (s == 3'd7);
        return e;
    endfunction

    // Model: the stage is a 2-deep FIFO whose head is the output beat.
    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            acc = in_valid && (exp_q.size() < 2);
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(model(instr, sel, tag));
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            check("rdy32", rdy32, exp_q.size() < 2);
            check("rdy64", rdy64, exp_q.size() < 2);
            check("ov32", ov32, exp_q.size() > 0);
            check("ov64", ov64, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("imm32", imm32, exp_q[0].imm32);
                check("imm64", imm64, exp_q[0].imm64);
                check("tag32", tag32, exp_q[0].tag);
                check("tag64", tag64, exp_q[0].tag);
                check("ill32", ill32, exp_q[0].ill32);
                check("ill64", ill64, exp_q[0].ill64);
            end
        end
    end

    // Must be called just after a rising edge; holds the beat until accepted.
    task automatic push(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t);
        bit acc = 1'b0;
        int n = 0;
        instr = ins; sel = s; tag = t; in_valid = 1'b1;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = rdy32;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_err++;
            $display("FAIL push_timeout: beat %h not accepted after %0d cycles", ins, n);
        end
    endtask

    task automatic send1(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t);
        instr = ins; sel = s; tag = t; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ov32", ov32, 0);
        check("reset_ov64", ov64, 0);
        check("reset_rdy32", rdy32, 1);
        check("reset_rdy64", rdy64, 1);
        check("reset_imm64", imm64, 0);
        check("reset_imm32", imm32, 0);
        check("reset_tag32", tag32, 0);
        check("reset_ill32", ill32, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        out_ready = 1'b1;

        send1(32'hFFF00093, 3'd0, 8'h11);
        check("i_ov", ov32, 1);
        check("i_imm32", imm32, 32'hFFFFFFFF);
        check("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        check("i_tag", tag32, 8'h11);
        check("i_ill", ill32, 0);

        instr = 32'hFE000EE3; sel = 3'd2; tag = 8'h21; in_valid = 1'b1;
        @(posedge clk); #1 instr = 32'h12345037; sel = 3'd4; tag = 8'h22;
        @(negedge clk);
        check("b_imm32", imm32, 32'hFFFFFFFC);
        check("b_imm64", imm64, 64'hFFFFFFFFFFFFFFFC);
        @(posedge clk); #1 instr = 32'h0080006F; sel = 3'd3; tag = 8'h23;
        @(negedge clk);
        check("u_imm32", imm32, 32'h12345000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("j_imm32", imm32, 32'h00000008);
        check("j_tag", tag32, 8'h23);

        send1(32'h03F00013, 3'd6, 8'h31);
        check("shamt_imm64", imm64, 64'h3F);
        check("shamt_ill64", ill64, 0);
        check("shamt_ill32", ill32, 1);
        send1(32'h12345678, 3'd7, 8'h32);
        check("rsvd_imm64", imm64, 0);
        check("rsvd_ill64", ill64, 1);
        check("rsvd_ill32", ill32, 1);
        send1(32'h000F8073, 3'd5, 8'h33);
        check("z_imm32", imm32, 32'h1F);
        check("z_imm64", imm64, 64'h1F);

        // Backpressure: two beats fit, the third waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        instr = 32'h00500093; sel = 3'd0; tag = 8'hA1; in_valid = 1'b1;
        @(negedge clk);
        check("bp_rdy0", rdy32, 1);
        @(posedge clk); #1 instr = 32'hFE112E23; sel = 3'd1; tag = 8'hA2;
        @(negedge clk);
        check("bp_imm_a", imm32, 32'd5);
        check("bp_rdy1", rdy32, 1);
        @(posedge clk); #1 instr = 32'hABCDE0B7; sel = 3'd4; tag = 8'hA3;
        @(negedge clk);
        check("bp_rdy2", rdy32, 0);
        check("bp_hold_tag", tag32, 8'hA1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_rdy3", rdy64, 0);
        check("bp_hold_imm", imm32, 32'd5);
        check("bp_hold_ov", ov32, 1);
        out_ready = 1'b1;
        begin
            int k = 0;
            while (!rdy32 && k < 10) begin
                @(negedge clk);
                k++;
            end
            n_checks++;
            if (k >= 10) begin
                n_err++;
                $display("FAIL bp_drain: in_ready stayed %b", rdy32);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_drained_rdy", rdy32, 1);
        check("bp_drained_ov", ov32, 0);

        // Randomized traffic with random consumer stalls.
        @(posedge clk); #1;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end else begin
                        push($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
                    end
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset while both entries hold beats.
        out_ready = 1'b0;
        push(32'h80000037, 3'd4, 8'hC1);
        push(32'h7FF00093, 3'd0, 8'hC2);
        @(negedge clk);
        check("full_rdy", rdy32, 0);
        check("full_ov", ov32, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov32", ov32, 0);
        check("arst_ov64", ov64, 0);
        check("arst_rdy32", rdy32, 1);
        check("arst_rdy64", rdy64, 1);
        check("arst_imm64", imm64, 0);
        check("arst_tag32", tag32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send1(32'h80000037, 3'd4, 8'hC3);
        check("post_rst_imm64", imm64, 64'hFFFFFFFF80000000);
        check("post_rst_imm32", imm32, 32'h80000000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It covers all RV32I/RV64I immediate formats (I, S, B, U, J), CSR zimm and shift-amount fields, and flags illegal selects. Each instruction is carried through one registered stage with a valid/ready handshake and a 2-entry skid buffer, so in_ready_o is fully registered. An optional tag is passed through unchanged so decode can associate the result with its PC or ROB slot.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; any other value is an elaboration error.
TAG_W, 8, width of the pass-through tag; minimum 1.

Ports:
clk_i  in  1  clock, all state on the rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
instr_i  in  32  raw instruction word
ImmSrc_i  in  3  format select: 0 I, 1 S, 2 B, 3 J, 4 U, 5 Z (CSR zimm), 6 SHAMT, 7 reserved
tag_i  in  TAG_W  opaque tag
out_valid_o  out  1  output beat valid
out_ready_i  in  1  consumer ready
ImmOp_o  out  XLEN  extended immediate
tag_o  out  TAG_W  tag of the output beat
illegal_o  out  1  select was reserved (7), or SHAMT with XLEN=32 and instr_i[25]=1

Behaviour:
- Reset (async assert, sync deassert by system): out_valid_o=0, ImmOp_o=0, tag_o=0, illegal_o=0, both buffer entries invalid, in_ready_o=1.
- Extension is combinational on input; sign bit s = instr_i[31]; all fills extend to XLEN:
  - I: s-ext instr[31:20]
  - S: s-ext {instr[31:25], instr[11:7]}
  - B: s-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: s-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - U: s-ext {instr[31:12], 12'b0}; upper bits are 1s for XLEN=64 when s=1
  - Z: zero-ext instr[19:15]
  - SHAMT: zero-ext instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32)
  - 7: ImmOp=0, illegal=1
- Latency: an accepted beat appears on the output on the next edge when the output register is empty or draining. Throughput is 1 beat/cycle.
- Output register (OR) plus skid entry (SK):
  - Accept when in_ready_o=1.
  - If OR is empty, or OR fires (out_valid_o && out_ready_i): OR loads from SK if SK is valid, else from the incoming beat.
  - If OR is held (valid and out_ready_i=0): the incoming beat goes to SK.
  - in_ready_o is a register, equal to !SK.valid for the next cycle.
  - Order is strictly FIFO; SK content always precedes any new beat.
- Simultaneous: OR fires, SK valid, new beat accepted → OR←SK, SK←new, in_ready_o stays 0 until SK drains.
- Full: OR and SK valid → in_ready_o=0 and input is ignored. in_valid_i while not ready has no effect.
- Output stability: while out_valid_o=1 and out_ready_i=0, ImmOp_o, tag_o and illegal_o must not change.
- Reset mid-operation: all beats are discarded immediately and outputs return to reset values asynchronously.
- No combinational path from out_ready_i to in_ready_o.

Test Plan:
- XLEN=32, I, instr 0xFFF00093, tag 0x11 → next cycle out_valid_o=1, ImmOp_o=0xFFFFFFFF, tag_o=0x11, illegal_o=0.
- Back-to-back with out_ready_i=1: B 0xFE000EE3, U 0x12345037, J 0x0080006F → consecutive cycles give 0xFFFFFFFC, 0x12345000, 0x00000008.
- Backpressure: out_ready_i=0 for 3 cycles while 3 beats are offered → 2 accepted, in_ready_o=0 from the following cycle, output held stable. Releasing out_ready_i → beats drain in order, in_ready_o returns to 1.
- XLEN=64: I 0xFFF00093 → 0xFFFFFFFFFFFFFFFF; SHAMT with instr[25:20]=0x3F → 0x3F, illegal_o=0. XLEN=32 with the same instr → illegal_o=1.
- ImmSrc=7 → ImmOp_o=0, illegal_o=1. Z with instr[19:15]=0x1F → 0x1F.
- Assert rst_ni low with OR and SK full → out_valid_o=0 and in_ready_o=1 immediately, before the next clock edge.
